// File: rtl/mem_access_stage_if.sv
// Data-memory valid/ready port between the memory stage (master) and data memory (slave).
interface mem_access_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic [7:0]  dm_be;
  logic        dm_ready;
  logic        dm_rvalid;
  logic [63:0] dm_rdata;

  modport master (output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
                  input  dm_ready, dm_rvalid, dm_rdata);
  modport slave  (input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
                  output dm_ready, dm_rvalid, dm_rdata);
endinterface

// File: rtl/mem_access_stage.sv
// Memory stage: runs the data-memory transaction for loads/stores, formats load data,
// and registers one result per instruction toward MEM/WB.
module mem_access_stage #(
  parameter int MAX_WAIT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ex_valid,
  input  logic               ex_mem_read,
  input  logic               ex_mem_write,
  input  logic [2:0]         ex_funct3,
  input  logic [63:0]        ex_addr,
  input  logic [63:0]        ex_wdata,
  input  logic [4:0]         ex_rd,
  input  logic [1:0]         ex_wb,
  output logic               stall,
  mem_access_stage_if.master dm,
  output logic               mem_valid,
  output logic [1:0]         mem_wb,
  output logic [63:0]        mem_read_data,
  output logic [4:0]         mem_rd,
  output logic [63:0]        mem_addr,
  output logic               mem_exc,
  output logic [1:0]         mem_exc_cause
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state, state_n;
  logic [CW-1:0] wait_cnt;

  logic        l_load, l_we;
  logic [63:0] l_addr, l_wdata;
  logic [2:0]  l_funct3;
  logic [4:0]  l_rd;
  logic [1:0]  l_wb;
  logic [7:0]  l_be;

  logic        is_acc, misal, latch, fin, fin_exc, timeout;
  logic [1:0]  fin_wb, fin_cause;
  logic [4:0]  fin_rd;
  logic [63:0] fin_addr, fin_data;
  logic [2:0]  lane;
  logic [7:0]  be_in;
  logic [63:0] wdata_sh, rsh, ld_fmt;

  assign lane     = ex_addr[2:0];
  assign is_acc   = ex_mem_read | ex_mem_write;
  assign wdata_sh = ex_wdata << {lane, 3'b000};
  assign timeout  = (state != IDLE) && (wait_cnt == CW'(MAX_WAIT - 1));

  // Size comes from funct3[1:0]; bit 2 only selects signedness for loads.
  always_comb begin
    misal = 1'b0;
    be_in = 8'hFF;
    case (ex_funct3[1:0])
      2'b00: be_in = 8'h01 << lane;
      2'b01: begin misal = ex_addr[0];     be_in = 8'h03 << lane; end
      2'b10: begin misal = |ex_addr[1:0];  be_in = 8'h0F << lane; end
      default: begin misal = |ex_addr[2:0]; be_in = 8'hFF; end
    endcase
  end

  assign rsh = dm.dm_rdata >> {l_addr[2:0], 3'b000};
  always_comb begin
    case (l_funct3)
      3'b000:  ld_fmt = {{56{rsh[7]}},  rsh[7:0]};
      3'b100:  ld_fmt = {56'd0,         rsh[7:0]};
      3'b001:  ld_fmt = {{48{rsh[15]}}, rsh[15:0]};
      3'b101:  ld_fmt = {48'd0,         rsh[15:0]};
      3'b010:  ld_fmt = {{32{rsh[31]}}, rsh[31:0]};
      3'b110:  ld_fmt = {32'd0,         rsh[31:0]};
      default: ld_fmt = rsh;
    endcase
  end

  assign dm.dm_req   = (state == REQ);
  assign dm.dm_we    = l_we;
  assign dm.dm_addr  = {l_addr[63:3], 3'b000};
  assign dm.dm_wdata = l_wdata;
  assign dm.dm_be    = l_be;

  always_comb begin
    state_n   = state;
    stall     = 1'b0;
    latch     = 1'b0;
    fin       = 1'b0;
    fin_wb    = 2'b00;
    fin_rd    = l_rd;
    fin_addr  = l_addr;
    fin_data  = '0;
    fin_exc   = 1'b0;
    fin_cause = 2'b00;
    case (state)
      IDLE: if (ex_valid) begin
        fin_rd   = ex_rd;
        fin_addr = ex_addr;
        if (!is_acc) begin
          fin    = 1'b1;
          fin_wb = ex_wb;
        end else if (misal) begin
          fin       = 1'b1;
          fin_exc   = 1'b1;
          fin_cause = ex_mem_read ? 2'b01 : 2'b10;
        end else begin
          stall   = 1'b1;
          latch   = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        // A posted store completes on dm_ready even in the timeout cycle.
        if (dm.dm_ready && !l_load) begin
          fin     = 1'b1;
          fin_wb  = l_wb;
          state_n = IDLE;
        end else if (timeout) begin
          fin       = 1'b1;
          fin_exc   = 1'b1;
          fin_cause = 2'b11;
          state_n   = IDLE;
        end else begin
          stall = 1'b1;
          if (dm.dm_ready) state_n = RESP;
        end
      end
      RESP: begin
        if (dm.dm_rvalid) begin
          fin      = 1'b1;
          fin_wb   = l_wb;
          fin_data = ld_fmt;
          state_n  = IDLE;
        end else if (timeout) begin
          fin       = 1'b1;
          fin_exc   = 1'b1;
          fin_cause = 2'b11;
          state_n   = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      // Counter spans REQ and RESP together; it is zero on entry to REQ.
      if (state == IDLE || state_n == IDLE) wait_cnt <= '0;
      else                                  wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      l_load   <= 1'b0;
      l_we     <= 1'b0;
      l_addr   <= '0;
      l_wdata  <= '0;
      l_funct3 <= '0;
      l_rd     <= '0;
      l_wb     <= '0;
      l_be     <= '0;
    end else if (latch) begin
      l_load   <= ex_mem_read;
      l_we     <= ~ex_mem_read;
      l_addr   <= ex_addr;
      l_wdata  <= wdata_sh;
      l_funct3 <= ex_funct3;
      l_rd     <= ex_rd;
      l_wb     <= ex_wb;
      l_be     <= be_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid     <= 1'b0;
      mem_wb        <= '0;
      mem_read_data <= '0;
      mem_rd        <= '0;
      mem_addr      <= '0;
      mem_exc       <= 1'b0;
      mem_exc_cause <= '0;
    end else begin
      mem_valid <= fin;
      mem_exc   <= fin & fin_exc;
      if (fin) begin
        mem_wb        <= fin_wb;
        mem_read_data <= fin_data;
        mem_rd        <= fin_rd;
        mem_addr      <= fin_addr;
        mem_exc_cause <= fin_cause;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: expected results are queued at issue and a monitor
// process compares them against every mem_valid result.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [63:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_wb;
  logic        stall, mem_valid, mem_exc;
  logic [1:0]  mem_wb, mem_exc_cause;
  logic [63:0] mem_read_data, mem_addr;
  logic [4:0]  mem_rd;

  mem_access_stage_if dmi();

  mem_access_stage #(.MAX_WAIT(8)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_rd(ex_rd), .ex_wb(ex_wb), .stall(stall), .dm(dmi.master),
    .mem_valid(mem_valid), .mem_wb(mem_wb), .mem_read_data(mem_read_data),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_exc(mem_exc), .mem_exc_cause(mem_exc_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wb;
    logic [63:0] data;
    logic [4:0]  rd;
    logic [63:0] addr;
    logic        exc;
    logic [1:0]  cause;
  } res_t;

  res_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] wb, input logic [63:0] data, input logic [4:0] rd,
                      input logic [63:0] addr, input logic exc, input logic [1:0] cause);
    res_t r;
    r.wb = wb; r.data = data; r.rd = rd; r.addr = addr; r.exc = exc; r.cause = cause;
    exp_q.push_back(r);
  endtask

  task automatic set_ex(input logic rd_, input logic wr_, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [4:0] rd, input logic [1:0] wb);
    ex_valid = 1'b1; ex_mem_read = rd_; ex_mem_write = wr_; ex_funct3 = f3;
    ex_addr = addr; ex_wdata = wdata; ex_rd = rd; ex_wb = wb;
  endtask

  task automatic monitor();
    res_t e;
    forever begin
      @(negedge clk);
      if (!reset && mem_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL result: unexpected mem_valid rd=%0d addr=0x%0h", mem_rd, mem_addr);
        end else begin
          e = exp_q.pop_front();
          if ({mem_wb, mem_read_data, mem_rd, mem_addr, mem_exc, mem_exc_cause} !==
              {e.wb, e.data, e.rd, e.addr, e.exc, e.cause}) begin
            errors++;
            $display("FAIL result: got wb=%b data=0x%0h rd=%0d addr=0x%0h exc=%b cause=%b expected wb=%b data=0x%0h rd=%0d addr=0x%0h exc=%b cause=%b",
                     mem_wb, mem_read_data, mem_rd, mem_addr, mem_exc, mem_exc_cause,
                     e.wb, e.data, e.rd, e.addr, e.exc, e.cause);
          end
        end
      end
    end
  endtask

  // Aligned access: checks request lines cycle by cycle; caller pushes the expected result.
  task automatic mem_op(input logic rd_, input logic wr_, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [4:0] rd, input logic [1:0] wb,
                        input int ready_dly, input int rv_dly, input logic [63:0] rdata,
                        input logic [7:0] exp_be, input logic [63:0] exp_wd);
    logic is_st;
    is_st = wr_ & ~rd_;
    set_ex(rd_, wr_, f3, addr, wdata, rd, wb);
    @(negedge clk);
    chk1("idle_stall", stall, 1'b1);
    chk1("idle_noreq", dmi.dm_req, 1'b0);
    tick();
    for (int i = 0; i < ready_dly; i++) begin
      @(negedge clk);
      chk1("req_wait_req", dmi.dm_req, 1'b1);
      chk1("req_wait_stall", stall, 1'b1);
      chk64("req_wait_addr", dmi.dm_addr, {addr[63:3], 3'b000});
      chk64("req_wait_be", {56'd0, dmi.dm_be}, {56'd0, exp_be});
      chk64("req_wait_wdata", dmi.dm_wdata, exp_wd);
      tick();
    end
    dmi.dm_ready = 1'b1;
    @(negedge clk);
    chk1("req_req", dmi.dm_req, 1'b1);
    chk1("req_we", dmi.dm_we, is_st);
    chk64("req_addr", dmi.dm_addr, {addr[63:3], 3'b000});
    chk64("req_be", {56'd0, dmi.dm_be}, {56'd0, exp_be});
    chk64("req_wdata", dmi.dm_wdata, exp_wd);
    chk1("req_stall", stall, ~is_st);
    tick();
    dmi.dm_ready = 1'b0;
    if (!is_st) begin
      for (int i = 1; i < rv_dly; i++) begin
        @(negedge clk);
        chk1("resp_stall", stall, 1'b1);
        chk1("resp_noreq", dmi.dm_req, 1'b0);
        tick();
      end
      dmi.dm_rvalid = 1'b1;
      dmi.dm_rdata  = rdata;
      @(negedge clk);
      chk1("rvalid_stall", stall, 1'b0);
      tick();
      dmi.dm_rvalid = 1'b0;
    end
    ex_valid = 1'b0;
    @(negedge clk);
    chk1("done_valid", mem_valid, 1'b1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    set_ex(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 2'd0);
    ex_valid = 1'b0;
    dmi.dm_ready = 1'b0; dmi.dm_rvalid = 1'b0; dmi.dm_rdata = '0;
    fork monitor(); join_none
    tick(); tick();
    @(negedge clk);
    chk1("rst_valid", mem_valid, 1'b0);
    chk1("rst_req", dmi.dm_req, 1'b0);
    chk1("rst_exc", mem_exc, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    tick();
    reset = 1'b0;

    // Non-memory instructions back to back, then a bubble.
    set_ex(1'b0, 1'b0, 3'd3, 64'h55, 64'h0, 5'd3, 2'b01);
    push(2'b01, 64'd0, 5'd3, 64'h55, 1'b0, 2'b00);
    @(negedge clk); chk1("alu_stall", stall, 1'b0);
    tick();
    set_ex(1'b0, 1'b0, 3'd0, 64'h66, 64'h0, 5'd4, 2'b00);
    push(2'b00, 64'd0, 5'd4, 64'h66, 1'b0, 2'b00);
    @(negedge clk); chk1("alu2_stall", stall, 1'b0);
    tick();
    ex_valid = 1'b0;
    tick();
    @(negedge clk); chk1("bubble", mem_valid, 1'b0);
    tick();

    // Loads
    push(2'b11, 64'h1122334455667788, 5'd5, 64'h1000, 1'b0, 2'b00);
    mem_op(1'b1, 1'b0, 3'b011, 64'h1000, 64'd0, 5'd5, 2'b11, 0, 2, 64'h1122334455667788, 8'hFF, 64'd0);
    push(2'b11, 64'hFFFFFFFFFFFFFF80, 5'd6, 64'h1003, 1'b0, 2'b00);
    mem_op(1'b1, 1'b0, 3'b000, 64'h1003, 64'd0, 5'd6, 2'b11, 0, 1, 64'h0000000080000000, 8'h08, 64'd0);
    push(2'b11, 64'h0000000000000080, 5'd7, 64'h1003, 1'b0, 2'b00);
    mem_op(1'b1, 1'b0, 3'b100, 64'h1003, 64'd0, 5'd7, 2'b11, 1, 1, 64'h0000000080000000, 8'h08, 64'd0);
    push(2'b11, 64'hFFFFFFFFFFFF8001, 5'd8, 64'h1006, 1'b0, 2'b00);
    mem_op(1'b1, 1'b0, 3'b001, 64'h1006, 64'd0, 5'd8, 2'b11, 0, 1, 64'h8001000000000000, 8'hC0, 64'd0);
    push(2'b11, 64'hFFFFFFFF80000000, 5'd9, 64'h1004, 1'b0, 2'b00);
    mem_op(1'b1, 1'b0, 3'b010, 64'h1004, 64'd0, 5'd9, 2'b11, 0, 1, 64'h8000000000000000, 8'hF0, 64'd0);
    push(2'b11, 64'h0000000080000000, 5'd9, 64'h1004, 1'b0, 2'b00);
    mem_op(1'b1, 1'b0, 3'b110, 64'h1004, 64'd0, 5'd9, 2'b11, 0, 1, 64'h8000000000000000, 8'hF0, 64'd0);
    // Read and write both set behaves as a load.
    push(2'b11, 64'hDEADBEEF00C0FFEE, 5'd12, 64'h1008, 1'b0, 2'b00);
    mem_op(1'b1, 1'b1, 3'b011, 64'h1008, 64'h99, 5'd12, 2'b11, 0, 1, 64'hDEADBEEF00C0FFEE, 8'hFF, 64'h99);

    // Stores
    push(2'b10, 64'd0, 5'd13, 64'h2006, 1'b0, 2'b00);
    mem_op(1'b0, 1'b1, 3'b001, 64'h2006, 64'hABCD, 5'd13, 2'b10, 3, 0, 64'd0, 8'hC0, 64'hABCD000000000000);
    push(2'b00, 64'd0, 5'd14, 64'h3000, 1'b0, 2'b00);
    mem_op(1'b0, 1'b1, 3'b011, 64'h3000, 64'h0102030405060708, 5'd14, 2'b00, 0, 0, 64'd0, 8'hFF, 64'h0102030405060708);
    push(2'b00, 64'd0, 5'd15, 64'h3005, 1'b0, 2'b00);
    mem_op(1'b0, 1'b1, 3'b100, 64'h3005, 64'h5A, 5'd15, 2'b00, 1, 0, 64'd0, 8'h20, 64'h00005A0000000000);

    // Misaligned accesses: no request, exception next edge.
    set_ex(1'b1, 1'b0, 3'b010, 64'h1002, 64'd0, 5'd16, 2'b11);
    push(2'b00, 64'd0, 5'd16, 64'h1002, 1'b1, 2'b01);
    @(negedge clk);
    chk1("mis_ld_stall", stall, 1'b0);
    chk1("mis_ld_req", dmi.dm_req, 1'b0);
    tick();
    set_ex(1'b0, 1'b1, 3'b011, 64'h2004, 64'd1, 5'd17, 2'b00);
    push(2'b00, 64'd0, 5'd17, 64'h2004, 1'b1, 2'b10);
    @(negedge clk);
    chk1("mis_sd_stall", stall, 1'b0);
    chk1("mis_ld_exc", mem_exc, 1'b1);
    tick();
    ex_valid = 1'b0;
    @(negedge clk); chk1("mis_sd_req", dmi.dm_req, 1'b0);
    tick();

    // Timeout: ready never comes; stall drops in the 8th REQ cycle.
    set_ex(1'b1, 1'b0, 3'b011, 64'h4000, 64'd0, 5'd18, 2'b11);
    push(2'b00, 64'd0, 5'd18, 64'h4000, 1'b1, 2'b11);
    @(negedge clk); chk1("to_idle_stall", stall, 1'b1);
    tick();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk1("to_req", dmi.dm_req, 1'b1);
      chk1("to_stall", stall, (i < 8));
      tick();
    end
    set_ex(1'b0, 1'b0, 3'd0, 64'h77, 64'd0, 5'd10, 2'b01);
    push(2'b01, 64'd0, 5'd10, 64'h77, 1'b0, 2'b00);
    @(negedge clk);
    chk1("to_after_req", dmi.dm_req, 1'b0);
    chk1("to_after_stall", stall, 1'b0);
    chk64("to_cause", {62'd0, mem_exc_cause}, 64'd3);
    tick();
    ex_valid = 1'b0;
    tick();

    // Reset while waiting in RESP; a late rvalid must not produce a result.
    set_ex(1'b1, 1'b0, 3'b011, 64'h5000, 64'd0, 5'd11, 2'b11);
    tick();
    dmi.dm_ready = 1'b1;
    tick();
    dmi.dm_ready = 1'b0;
    @(negedge clk); chk1("rr_resp_stall", stall, 1'b1);
    reset = 1'b1;
    ex_valid = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk1("rr_req", dmi.dm_req, 1'b0);
    chk1("rr_valid", mem_valid, 1'b0);
    dmi.dm_rvalid = 1'b1;
    dmi.dm_rdata  = 64'hFFFF;
    tick();
    dmi.dm_rvalid = 1'b0;
    @(negedge clk); chk1("rr_late_rvalid", mem_valid, 1'b0);
    tick();

    // Recovery after reset.
    push(2'b11, 64'h00000000000000A5, 5'd19, 64'h6001, 1'b0, 2'b00);
    mem_op(1'b1, 1'b0, 3'b100, 64'h6001, 64'd0, 5'd19, 2'b11, 0, 1, 64'h000000000000A500, 8'h02, 64'd0);

    tick(); tick();
    chk64("drain", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
